board_game_engine: RTL and testbench
====================================

Name: board_game_engine

Overview:
Parametrised N×N, K-in-a-row successor to the team's 3×3 tic-tac-toe logic block.
- Adds a valid/ready move handshake, turn enforcement and per-move response codes.
- Uses a multi-cycle win scan through the last placed cell instead of a full-board combinational check.
- Sits between the input/UI controller (moves) and the display/score logic (board, winner).

Parameters:
N, 3, board side length; legal range 3..8
K, 3, stones in a line needed to win; legal range 3..N
START_PLAYER, 1, player that moves first after reset (1 = X, 2 = O)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high; clears the whole game
move_valid  in  1  host presents a move
move_ready  out  1  engine can take a move this cycle
move_pos  in  PW  cell index, row*N+col; PW = clog2(N*N), a derived localparam
move_player  in  2  player making the move (1 = X, 2 = O)
resp_valid  out  1  one-cycle pulse, one per handshake
resp_code  out  3  0 OK, 1 OCCUPIED, 2 OUT_OF_RANGE, 3 WRONG_TURN, 4 GAME_OVER
board  out  2*N*N  cell p occupies bits [2p+1:2p]; 00 empty, 01 X, 10 O
current_player  out  2  player expected to move next
move_count  out  clog2(N*N+1)  number of accepted moves
winner  out  2  0 none, 1 X, 2 O, 3 draw
game_over  out  1  1 once a win or draw is detected

Behaviour:
- Reset values, all asynchronous:
  - board = 0, winner = 0, game_over = 0, move_count = 0
  - current_player = START_PLAYER, resp_valid = 0, resp_code = 0
  - FSM in IDLE, move_ready = 1
- FSM states and move_ready:
  - IDLE and DONE: move_ready = 1.
  - CHECK: move_ready = 0.
- Handshake: a move is taken at rising edge E0 where move_valid && move_ready.
  - resp_valid = 1 for exactly the cycle after E0, with resp_code.
- Rejection priority, highest first:
  - GAME_OVER: FSM is in DONE.
  - OUT_OF_RANGE: move_pos >= N*N.
  - WRONG_TURN: move_player != current_player.
  - OCCUPIED: target cell is non-empty.
- A rejected move changes no state other than resp_*; the FSM stays in IDLE or DONE.
- Accepted move (resp_code = OK), at E0:
  - board cell written with move_player.
  - move_count incremented.
  - last_pos and last_player latched internally.
  - IDLE → CHECK, direction counter d = 0.
- CHECK occupies edges E1..E4, one direction per edge:
  - d0 horizontal, d1 vertical, d2 diagonal (down-right), d3 anti-diagonal (down-left).
  - Each edge computes the contiguous run of last_player through last_pos along ±d, using the registered board.
  - Run span is offsets −(K−1)..+(K−1). Cells outside the board terminate the run.
  - Row/column bounds are checked explicitly; no wrap from column N−1 to column 0 of the next row.
  - Hit when run >= K; the hit flag is sticky across E1..E4.
- Result at E4, fixed latency with no early exit:
  - Hit: winner = last_player, game_over = 1, FSM → DONE.
  - Else if move_count == N*N: winner = 3, game_over = 1, FSM → DONE.
  - Else: current_player toggles (1↔2), FSM → IDLE.
  - First new move can be taken at E5.
- current_player does not toggle on the final (winning or drawing) move.
- DONE is left only via reset.
- Reset mid-CHECK: abandon the scan; all outputs return to reset values immediately.
- move_player values 0 or 3 always produce WRONG_TURN.

Decomposition:
- Shared package board_game_pkg holds:
  - cell encoding constants: EMPTY, PX, PO.
  - winner codes, including DRAW = 3.
  - resp_code enumeration.
  - FSM state enumeration.
  - direction enumeration with (dr, dc) step table.
- One sub-module, line_run_counter:
  - Combinational, parametrised by N and K.
  - Inputs: board, pos, player, direction.
  - Output: run >= K flag.
  - Instantiated once and time-multiplexed over d.

Test Plan:
- N=3,K=3, X at 0, O at 3, X at 1, O at 4, X at 2, each with move_player correct:
  - All resp_code = 0.
  - After the 5th move's E4: winner = 1, game_over = 1.
  - Every move_ready low window lasts 4 cycles.
- N=3: X at 4 then X at 0:
  - Second move → resp_code = 3.
  - O at 4 → resp_code = 1.
  - pos 9 → resp_code = 2.
  - board, move_count and current_player unchanged by all three.
- N=3, full-board no-line sequence X4 O0 X2 O6 X3 O5 X1 O7 X8:
  - winner = 3, game_over = 1, move_count = 9.
  - Any further move → resp_code = 4.
- N=5,K=3, X at 3, 4, 5 (5 wraps to row 1) with O filler at 20, 21:
  - No win; game_over stays 0.
  - Confirms no row wrap.
- N=5,K=4, anti-diagonal X at 4, 8, 12, 16 with O filler elsewhere:
  - winner = 1 exactly at E4 of the 16 move.
- Reset asserted at E2 of a CHECK:
  - board = 0, move_ready = 1, current_player = START_PLAYER in the same cycle.
  - A new move is accepted on the next edge after reset deasserts.

Source files
------------

// File: rtl/board_game_pkg.sv
// Shared types and constants for the N x N, K-in-a-row board game engine.
// Holds the cell encoding, winner codes, response codes, FSM states and the
// scan-direction step table used by the win scanner.
package board_game_pkg;

  // Cell encoding
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] PX    = 2'b01;
  localparam logic [1:0] PO    = 2'b10;

  // Winner codes
  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_X    = 2'd1;
  localparam logic [1:0] WIN_O    = 2'd2;
  localparam logic [1:0] DRAW     = 2'd3;

  typedef enum logic [2:0] {
    RESP_OK           = 3'd0,
    RESP_OCCUPIED     = 3'd1,
    RESP_OUT_OF_RANGE = 3'd2,
    RESP_WRONG_TURN   = 3'd3,
    RESP_GAME_OVER    = 3'd4
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Scan directions: horizontal, vertical, diagonal down-right, anti-diagonal down-left
  typedef enum logic [1:0] {
    DIR_H = 2'd0,
    DIR_V = 2'd1,
    DIR_D = 2'd2,
    DIR_A = 2'd3
  } dir_e;

  // Row step of a direction
  function automatic int dir_dr(input dir_e d);
    case (d)
      DIR_H:   return 0;
      default: return 1;
    endcase
  endfunction

  // Column step of a direction
  function automatic int dir_dc(input dir_e d);
    case (d)
      DIR_H:   return 1;
      DIR_V:   return 0;
      DIR_D:   return 1;
      default: return -1;
    endcase
  endfunction

endpackage

// File: rtl/board_game_engine_line_run_counter.sv
// Combinational run counter: counts contiguous cells of 'player' through
// 'pos' along +/- 'dir' (offsets -(K-1)..+(K-1)) and flags run >= K.
// Ports: board (2 bits per cell), pos (cell index), player, dir -> hit.
module line_run_counter
  import board_game_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned K = 3,
  localparam int unsigned PW = $clog2(N * N),
  localparam int unsigned BW = 2 * N * N
) (
  input  logic [BW-1:0] board,
  input  logic [PW-1:0] pos,
  input  logic [1:0]    player,
  input  dir_e          dir,
  output logic          hit
);

  int  r0, c0, dr, dc, r, c, run;
  logic fwd, bwd;

  // Each side stops at the first non-matching or off-board cell; row and
  // column bounds are checked separately so runs never wrap across rows.
  always_comb begin
    r0  = int'(pos) / int'(N);
    c0  = int'(pos) % int'(N);
    dr  = dir_dr(dir);
    dc  = dir_dc(dir);
    run = 1;
    fwd = 1'b1;
    bwd = 1'b1;
    r   = 0;
    c   = 0;
    for (int i = 1; i < int'(K); i++) begin
      r = r0 + i * dr;
      c = c0 + i * dc;
      if (fwd && r >= 0 && r < int'(N) && c >= 0 && c < int'(N)) begin
        if (board[2 * (r * int'(N) + c) +: 2] == player) run = run + 1;
        else fwd = 1'b0;
      end else begin
        fwd = 1'b0;
      end
      r = r0 - i * dr;
      c = c0 - i * dc;
      if (bwd && r >= 0 && r < int'(N) && c >= 0 && c < int'(N)) begin
        if (board[2 * (r * int'(N) + c) +: 2] == player) run = run + 1;
        else bwd = 1'b0;
      end else begin
        bwd = 1'b0;
      end
    end
    hit = (run >= int'(K));
  end

endmodule

// File: rtl/board_game_engine.sv
// N x N, K-in-a-row board game engine with valid/ready move handshake,
// turn enforcement, per-move response codes and a 4-cycle win scan
// through the last placed cell.
// Ports: clk, reset (async, active-high); move_valid/move_ready/move_pos/
// move_player in; resp_valid/resp_code, board, current_player, move_count,
// winner, game_over out (all registered).
module board_game_engine
  import board_game_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned K = 3,
  parameter int unsigned START_PLAYER = 1,
  localparam int unsigned PW = $clog2(N * N),
  localparam int unsigned CW = $clog2(N * N + 1),
  localparam int unsigned BW = 2 * N * N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          move_valid,
  output logic          move_ready,
  input  logic [PW-1:0] move_pos,
  input  logic [1:0]    move_player,
  output logic          resp_valid,
  output logic [2:0]    resp_code,
  output logic [BW-1:0] board,
  output logic [1:0]    current_player,
  output logic [CW-1:0] move_count,
  output logic [1:0]    winner,
  output logic          game_over
);

  state_e        state_q, state_n;
  dir_e          dir_q, dir_n;
  logic          hit_q, hit_n;
  logic [PW-1:0] last_pos_q, last_pos_n;
  logic [1:0]    last_pl_q, last_pl_n;
  logic [BW-1:0] board_n;
  logic [1:0]    cp_n, win_n;
  logic [CW-1:0] mc_n;
  logic          go_n, rv_n, ready_n;
  logic [2:0]    rc_n;
  logic          in_range, scan_hit, hit_any;
  logic [1:0]    tgt_cell;

  // Single scanner, time-multiplexed over the four directions
  line_run_counter #(.N(N), .K(K)) u_scan (
    .board  (board),
    .pos    (last_pos_q),
    .player (last_pl_q),
    .dir    (dir_q),
    .hit    (scan_hit)
  );

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      dir_q          <= DIR_H;
      hit_q          <= 1'b0;
      last_pos_q     <= '0;
      last_pl_q      <= EMPTY;
      board          <= '0;
      current_player <= 2'(START_PLAYER);
      move_count     <= '0;
      winner         <= WIN_NONE;
      game_over      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_code      <= RESP_OK;
      move_ready     <= 1'b1;
    end else begin
      state_q        <= state_n;
      dir_q          <= dir_n;
      hit_q          <= hit_n;
      last_pos_q     <= last_pos_n;
      last_pl_q      <= last_pl_n;
      board          <= board_n;
      current_player <= cp_n;
      move_count     <= mc_n;
      winner         <= win_n;
      game_over      <= go_n;
      resp_valid     <= rv_n;
      resp_code      <= rc_n;
      move_ready     <= ready_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n    = state_q;
    dir_n      = dir_q;
    hit_n      = hit_q;
    last_pos_n = last_pos_q;
    last_pl_n  = last_pl_q;
    board_n    = board;
    cp_n       = current_player;
    mc_n       = move_count;
    win_n      = winner;
    go_n       = game_over;
    rv_n       = 1'b0;
    rc_n       = resp_code;
    in_range   = (32'(move_pos) < N * N);
    tgt_cell   = board[{move_pos, 1'b0} +: 2];
    hit_any    = hit_q | scan_hit;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (move_valid && move_ready) begin
          rv_n = 1'b1;
          if (state_q == ST_DONE)               rc_n = RESP_GAME_OVER;
          else if (!in_range)                   rc_n = RESP_OUT_OF_RANGE;
          else if (move_player != current_player) rc_n = RESP_WRONG_TURN;
          else if (tgt_cell != EMPTY)           rc_n = RESP_OCCUPIED;
          else begin
            rc_n                          = RESP_OK;
            board_n[{move_pos, 1'b0} +: 2] = move_player;
            mc_n                          = move_count + CW'(1);
            last_pos_n                    = move_pos;
            last_pl_n                     = move_player;
            dir_n                         = DIR_H;
            hit_n                         = 1'b0;
            state_n                       = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        hit_n = hit_any;
        // Fixed four-edge scan; the result is resolved on the last direction
        if (dir_q == DIR_A) begin
          if (hit_any) begin
            win_n   = last_pl_q;
            go_n    = 1'b1;
            state_n = ST_DONE;
          end else if (move_count == CW'(N * N)) begin
            win_n   = DRAW;
            go_n    = 1'b1;
            state_n = ST_DONE;
          end else begin
            cp_n    = (current_player == PX) ? PO : PX;
            state_n = ST_IDLE;
          end
        end else begin
          dir_n = dir_e'(dir_q + 2'd1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    ready_n = (state_n != ST_CHECK);
  end

endmodule

// File: tb/tb_board_game_engine.sv
// Directed bench: three engines (N3K3, N5K3, N5K4) sharing clock, reset and
// move bus; each move is routed to one engine by its move_valid bit.
module tb_board_game_engine;

  logic        clk;
  logic        reset;
  logic [2:0]  mv;
  logic [4:0]  mp;
  logic [1:0]  mpl;
  logic [2:0]  rdy, rv, go;
  logic [2:0]  rc [3];
  logic [1:0]  wn [3];
  logic [1:0]  cp [3];
  logic [3:0]  mc0;
  logic [4:0]  mc1, mc2;
  logic [17:0] b0;
  logic [49:0] b1, b2;

  int checks = 0;
  int errors = 0;

  board_game_engine #(.N(3), .K(3), .START_PLAYER(1)) dut0 (
    .clk(clk), .reset(reset), .move_valid(mv[0]), .move_ready(rdy[0]),
    .move_pos(mp[3:0]), .move_player(mpl), .resp_valid(rv[0]), .resp_code(rc[0]),
    .board(b0), .current_player(cp[0]), .move_count(mc0), .winner(wn[0]),
    .game_over(go[0]));

  board_game_engine #(.N(5), .K(3), .START_PLAYER(1)) dut1 (
    .clk(clk), .reset(reset), .move_valid(mv[1]), .move_ready(rdy[1]),
    .move_pos(mp), .move_player(mpl), .resp_valid(rv[1]), .resp_code(rc[1]),
    .board(b1), .current_player(cp[1]), .move_count(mc1), .winner(wn[1]),
    .game_over(go[1]));

  board_game_engine #(.N(5), .K(4), .START_PLAYER(1)) dut2 (
    .clk(clk), .reset(reset), .move_valid(mv[2]), .move_ready(rdy[2]),
    .move_pos(mp), .move_player(mpl), .resp_valid(rv[2]), .resp_code(rc[2]),
    .board(b2), .current_player(cp[2]), .move_count(mc2), .winner(wn[2]),
    .game_over(go[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One handshake on engine s; accepted moves must hold move_ready low 4 cycles
  task automatic do_move(input int s, input int pos, input logic [1:0] pl,
                         input logic [2:0] exp, input string tag);
    int n;
    @(negedge clk);
    mp    = 5'(pos);
    mpl   = pl;
    mv[s] = 1'b1;
    chk({tag, "_ready"}, 64'(rdy[s]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    mv[s] = 1'b0;
    chk({tag, "_rv"}, 64'(rv[s]), 64'd1);
    chk({tag, "_code"}, 64'(rc[s]), 64'(exp));
    if (exp == 3'd0) begin
      chk({tag, "_go_early"}, 64'(go[s]), 64'd0);
      n = 0;
      while (rdy[s] !== 1'b1 && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk({tag, "_busy"}, 64'(n), 64'd4);
    end else begin
      chk({tag, "_ready_rej"}, 64'(rdy[s]), 64'd1);
      @(negedge clk);
    end
    chk({tag, "_rv_pulse"}, 64'(rv[s]), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    mv    = 3'b000;
    mp    = '0;
    mpl   = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_board", 64'(b0), 64'd0);
    chk("rst_ready", 64'(rdy), 64'h7);
    chk("rst_cp", 64'(cp[0]), 64'd1);
    chk("rst_mc", 64'(mc0), 64'd0);
    chk("rst_winner", 64'(wn[0]), 64'd0);
    chk("rst_go", 64'(go), 64'd0);
    chk("rst_rv", 64'(rv), 64'd0);
    chk("rst_rc", 64'(rc[0]), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // N5K3: X at 3,4,5 -- 5 is row 1 col 0, so no row wrap win
    do_move(1, 3, 2'd1, 3'd0, "nw_x3");
    do_move(1, 20, 2'd2, 3'd0, "nw_o20");
    do_move(1, 4, 2'd1, 3'd0, "nw_x4");
    do_move(1, 21, 2'd2, 3'd0, "nw_o21");
    do_move(1, 5, 2'd1, 3'd0, "nw_x5");
    chk("nw_go", 64'(go[1]), 64'd0);
    chk("nw_winner", 64'(wn[1]), 64'd0);
    chk("nw_mc", 64'(mc1), 64'd5);
    chk("nw_cp", 64'(cp[1]), 64'd2);
    chk("nw_board", 64'(b1), 64'hA0000000540);

    // N5K4: anti-diagonal 4,8,12,16; O has only three in row 0
    do_move(2, 4, 2'd1, 3'd0, "ad_x4");
    do_move(2, 0, 2'd2, 3'd0, "ad_o0");
    do_move(2, 8, 2'd1, 3'd0, "ad_x8");
    do_move(2, 1, 2'd2, 3'd0, "ad_o1");
    do_move(2, 12, 2'd1, 3'd0, "ad_x12");
    chk("ad_winner3", 64'(wn[2]), 64'd0);
    do_move(2, 2, 2'd2, 3'd0, "ad_o2");
    chk("ad_go_o3", 64'(go[2]), 64'd0);
    do_move(2, 16, 2'd1, 3'd0, "ad_x16");
    chk("ad_winner", 64'(wn[2]), 64'd1);
    chk("ad_go", 64'(go[2]), 64'd1);
    chk("ad_cp", 64'(cp[2]), 64'd1);
    chk("ad_mc", 64'(mc2), 64'd7);

    // N3K3: X wins along row 0
    do_move(0, 0, 2'd1, 3'd0, "ga_x0");
    do_move(0, 3, 2'd2, 3'd0, "ga_o3");
    do_move(0, 1, 2'd1, 3'd0, "ga_x1");
    do_move(0, 4, 2'd2, 3'd0, "ga_o4");
    do_move(0, 2, 2'd1, 3'd0, "ga_x2");
    chk("ga_winner", 64'(wn[0]), 64'd1);
    chk("ga_go", 64'(go[0]), 64'd1);
    chk("ga_cp", 64'(cp[0]), 64'd1);
    chk("ga_mc", 64'(mc0), 64'd5);
    chk("ga_board", 64'(b0), 64'h295);

    // Rejections leave state untouched
    do_reset();
    do_move(0, 4, 2'd1, 3'd0, "rj_x4");
    do_move(0, 0, 2'd1, 3'd3, "rj_wrong");
    do_move(0, 4, 2'd2, 3'd1, "rj_occ");
    do_move(0, 9, 2'd2, 3'd2, "rj_oor");
    do_move(0, 1, 2'd3, 3'd3, "rj_pl3");
    chk("rj_board", 64'(b0), 64'h100);
    chk("rj_mc", 64'(mc0), 64'd1);
    chk("rj_cp", 64'(cp[0]), 64'd2);
    chk("rj_go", 64'(go[0]), 64'd0);

    // Full board with no line -> draw, then GAME_OVER for anything
    do_reset();
    do_move(0, 4, 2'd1, 3'd0, "dr_1");
    do_move(0, 0, 2'd2, 3'd0, "dr_2");
    do_move(0, 2, 2'd1, 3'd0, "dr_3");
    do_move(0, 6, 2'd2, 3'd0, "dr_4");
    do_move(0, 3, 2'd1, 3'd0, "dr_5");
    do_move(0, 5, 2'd2, 3'd0, "dr_6");
    do_move(0, 1, 2'd1, 3'd0, "dr_7");
    do_move(0, 7, 2'd2, 3'd0, "dr_8");
    do_move(0, 8, 2'd1, 3'd0, "dr_9");
    chk("dr_winner", 64'(wn[0]), 64'd3);
    chk("dr_go", 64'(go[0]), 64'd1);
    chk("dr_mc", 64'(mc0), 64'd9);
    chk("dr_board", 64'(b0), 64'h1A956);
    do_move(0, 0, 2'd1, 3'd4, "dr_over");
    do_move(0, 9, 2'd2, 3'd4, "dr_over_oor");
    chk("dr_mc_after", 64'(mc0), 64'd9);

    // Reset during a scan
    do_reset();
    @(negedge clk);
    mp = 5'd4; mpl = 2'd1; mv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mv[0] = 1'b0;
    chk("mr_busy", 64'(rdy[0]), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mr_board", 64'(b0), 64'd0);
    chk("mr_ready", 64'(rdy[0]), 64'd1);
    chk("mr_cp", 64'(cp[0]), 64'd1);
    chk("mr_mc", 64'(mc0), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    mp = 5'd0; mpl = 2'd1; mv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mv[0] = 1'b0;
    chk("mr_rv", 64'(rv[0]), 64'd1);
    chk("mr_code", 64'(rc[0]), 64'd0);
    chk("mr_board2", 64'(b0), 64'h1);

    repeat (6) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
